snoop_rx_arbiter: RTL and testbench

SNOOP_RX_ARBITER -- requirements
Module: snoop_rx_arbiter

---
 rtl/snoop_rx_arbiter.sv | 124 ++++++++++++
 tb/tb_snoop_rx_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/snoop_rx_arbiter.sv
// Snoop receive endpoint: round-robin arbitration of the crossbar slots that feed this CPU
// into an in-order FIFO toward the cache controller. Each entry carries its source CPU index.
package types;
    localparam int NUM_CPUS = 4;

    typedef struct packed {
        logic [3:0]  op;
        logic [27:0] addr;
    } xbar_msg_t;
endpackage

module snoop_rx_arbiter #(
    parameter int NUM_CPUS = types::NUM_CPUS,
    parameter int CPU_ID   = 0,
    parameter int DEPTH    = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_CPUS-2:0]                 in_valid,
    input  types::xbar_msg_t [NUM_CPUS-2:0]     in_msg,
    output logic [NUM_CPUS-2:0]                 in_ready,
    output logic                                out_valid,
    output types::xbar_msg_t                    out_msg,
    output logic [$clog2(NUM_CPUS)-1:0]         out_src,
    input  logic                                out_ready,
    output logic [$clog2(DEPTH):0]              count
);
    localparam int NSLOT = NUM_CPUS - 1;
    localparam int PTR_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int SW    = $clog2(NUM_CPUS);

    typedef struct packed {
        types::xbar_msg_t msg;
        logic [SW-1:0]    src;
    } entry_t;

    entry_t               mem_q [DEPTH];
    logic [AW-1:0]        head_q, head_d;
    logic [AW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [NSLOT-1:0][SW-1:0] slot_src;
    logic                 gnt_vld;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 full;
    logic                 push;
    logic                 pop;
    entry_t               wr_entry;
    int                   scan;

    // The crossbar row omits our own CPU, so slots at or above CPU_ID are shifted by one.
    for (genvar j = 0; j < NSLOT; j++) begin : g_src
        assign slot_src[j] = (j >= CPU_ID) ? SW'(j + 1) : SW'(j);
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = 0;
        for (int i = 0; i < NSLOT; i++) begin
            scan = int'(rr_ptr_q) + i;
            if (scan >= NSLOT) scan = scan - NSLOT;
            if (!gnt_vld && in_valid[scan]) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_W'(scan);
            end
        end
    end

    // No full-bypass: a pop in the same cycle does not open a slot while full.
    assign full      = (count_q == CW'(DEPTH));
    assign push      = gnt_vld && !full && rst_n;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        in_ready = '0;
        if (push) in_ready[gnt_idx] = 1'b1;
    end

    assign wr_entry.msg = in_msg[gnt_idx];
    assign wr_entry.src = slot_src[gnt_idx];

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            tail_d   = tail_q + AW'(1);
            rr_ptr_d = (int'(gnt_idx) == NSLOT - 1) ? '0 : gnt_idx + PTR_W'(1);
        end
        if (pop) head_d = head_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Storage is deliberately unreset; out_valid gates its visibility.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= wr_entry;
    end

    assign out_msg = mem_q[head_q].msg;
    assign out_src = mem_q[head_q].src;
    assign count   = count_q;

endmodule

// File: tb/tb_snoop_rx_arbiter.sv
// Scoreboard bench for snoop_rx_arbiter with NUM_CPUS=4, CPU_ID=1, DEPTH=4.
module tb_snoop_rx_arbiter;
    localparam int NUM_CPUS = 4;
    localparam int CPU_ID   = 1;
    localparam int DEPTH    = 4;
    localparam int NSLOT    = NUM_CPUS - 1;

    typedef struct packed {
        types::xbar_msg_t msg;
        logic [1:0]       src;
    } exp_t;

    logic                               clk;
    logic                               rst_n;
    logic [NSLOT-1:0]                   in_valid;
    types::xbar_msg_t [NSLOT-1:0]       in_msg;
    logic [NSLOT-1:0]                   in_ready;
    logic                               out_valid;
    types::xbar_msg_t                   out_msg;
    logic [1:0]                         out_src;
    logic                               out_ready;
    logic [2:0]                         count;

    exp_t sb[$];
    int   m_cnt;
    int   m_rr;
    int   n_vec;
    int   n_err;

    snoop_rx_arbiter #(.NUM_CPUS(NUM_CPUS), .CPU_ID(CPU_ID), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_msg    (in_msg),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_msg   (out_msg),
        .out_src   (out_src),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] src_of(input int slot);
        return (slot >= CPU_ID) ? 2'(slot + 1) : 2'(slot);
    endfunction

    // Called just after a falling edge; applies one cycle of stimulus and checks it.
    task automatic drive_cycle(input logic [NSLOT-1:0] v, input logic rdy);
        int   g;
        int   s;
        logic [NSLOT-1:0] exp_rdy;
        logic pop;
        exp_t e;
        in_valid  = v;
        out_ready = rdy;
        for (int j = 0; j < NSLOT; j++) in_msg[j] = types::xbar_msg_t'($urandom);
        #1;
        g = -1;
        if (m_cnt < DEPTH) begin
            for (int k = 0; k < NSLOT; k++) begin
                s = (m_rr + k) % NSLOT;
                if (g < 0 && v[s]) g = s;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_cnt != 0));
        chk("count", 64'(count), 64'(m_cnt));
        pop = (m_cnt != 0) && rdy;
        if (m_cnt != 0) begin
            e = sb[0];
            chk("out_msg", 64'(out_msg), 64'(e.msg));
            chk("out_src", 64'(out_src), 64'(e.src));
        end
        if (pop) void'(sb.pop_front());
        if (g >= 0) begin
            e.msg = in_msg[g];
            e.src = src_of(g);
            sb.push_back(e);
            m_rr  = (g + 1) % NSLOT;
        end
        m_cnt = m_cnt + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && m_cnt != 0; i++) drive_cycle('0, 1'b1);
        chk("drained", 64'(count), 64'(0));
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_cnt     = 0;
        m_rr      = 0;
        rst_n     = 1'b0;
        in_valid  = '1;
        in_msg    = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        rst_n = 1'b1;
        in_valid = '0;

        // single message from slot 1 arrives as source CPU 2
        drive_cycle(3'b010, 1'b0);
        drive_cycle(3'b000, 1'b1);
        // steer the pointer back to 0, then rotate over three held-valid slots
        drive_cycle(3'b100, 1'b1);
        drain();
        for (int i = 0; i < 6; i++) drive_cycle(3'b111, 1'b1);
        drain();

        // fill with consumer stalled, then release
        for (int i = 0; i < 6; i++) drive_cycle(3'b111, 1'b0);
        for (int i = 0; i < 6; i++) drive_cycle(3'b111, 1'b1);
        drain();

        // count=2 with simultaneous push and pop
        drive_cycle(3'b001, 1'b0);
        drive_cycle(3'b010, 1'b0);
        drive_cycle(3'b100, 1'b1);
        drive_cycle(3'b000, 1'b0);
        drain();

        // ten push/pop pairs across the pointer wrap
        for (int i = 0; i < 10; i++) drive_cycle(NSLOT'(1 << (i % NSLOT)), 1'b1);
        drain();

        // random traffic, including senders dropping valid while not granted
        for (int i = 0; i < 300; i++)
            drive_cycle(NSLOT'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        drain();

        // three buffered entries, pointer left at 2, then asynchronous reset mid-cycle
        drive_cycle(3'b001, 1'b0);
        drive_cycle(3'b100, 1'b0);
        drive_cycle(3'b010, 1'b0);
        in_valid = 3'b111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        m_cnt = 0;
        m_rr  = 0;
        drive_cycle(3'b000, 1'b1);
        drive_cycle(3'b111, 1'b0);
        drive_cycle(3'b000, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
